// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, divider stalls, redirect flushes.
// Define PIPELINE_HAZARD_CTRL_PERF_CNT_EN to build the stall/redirect counters.
module pipeline_hazard_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_mem_read,
   input  logic             ex_redirect,
   input  logic             ex_md_valid,
   input  logic             md_done,
   output logic             if_pc_en,
   output logic             if_id_en,
   output logic             id_ex_en,
   output logic             ex_mem_en,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             ex_mem_flush,
   output logic             md_start,
   output logic [1:0]       ctrl_state,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] redirect_count
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MD_WAIT  = 2'd1,
      REDIRECT = 2'd2
   } state_t;

   state_t state_q;
   state_t state_d;
   logic   load_use;
   logic   rs1_hit;
   logic   rs2_hit;

   assign rs1_hit  = id_uses_rs1 && (id_rs1 == ex_rd);
   assign rs2_hit  = id_uses_rs2 && (id_rs2 == ex_rd);
   assign load_use = ex_mem_read && (ex_rd != 5'd0) && (rs1_hit || rs2_hit);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = RUN;
      case (state_q)
         RUN: begin
            if (ex_redirect) begin
               state_d = REDIRECT;
            end else if (ex_md_valid) begin
               state_d = MD_WAIT;
            end else begin
               state_d = RUN;
            end
         end
         MD_WAIT: begin
            state_d = md_done ? RUN : MD_WAIT;
         end
         REDIRECT: begin
            state_d = RUN;
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end

   always_comb begin
      if_pc_en     = 1'b1;
      if_id_en     = 1'b1;
      id_ex_en     = 1'b1;
      ex_mem_en    = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
      md_start     = 1'b0;
      if (rst) begin
         if_pc_en  = 1'b0;
         if_id_en  = 1'b0;
         id_ex_en  = 1'b0;
         ex_mem_en = 1'b0;
      end else begin
         case (state_q)
            RUN: begin
               if (ex_redirect) begin
                  if_id_flush = 1'b1;
                  id_ex_flush = 1'b1;
               end else if (ex_md_valid) begin
                  md_start     = 1'b1;
                  if_pc_en     = 1'b0;
                  if_id_en     = 1'b0;
                  id_ex_en     = 1'b0;
                  ex_mem_flush = 1'b1;
               end else if (load_use) begin
                  if_pc_en    = 1'b0;
                  if_id_en    = 1'b0;
                  id_ex_flush = 1'b1;
               end
            end
            MD_WAIT: begin
               if (!md_done) begin
                  if_pc_en     = 1'b0;
                  if_id_en     = 1'b0;
                  id_ex_en     = 1'b0;
                  ex_mem_flush = 1'b1;
               end
            end
            // registered imem still presents the wrong-path word here
            REDIRECT: begin
               if_id_flush = 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   assign ctrl_state = state_q;

`ifdef PIPELINE_HAZARD_CTRL_PERF_CNT_EN
   logic [CNT_W-1:0] stall_q;
   logic [CNT_W-1:0] redir_q;
   logic             enter_redir;

   assign enter_redir = (state_q != REDIRECT) && (state_d == REDIRECT);

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= '0;
         redir_q <= '0;
      end else begin
         if (!if_pc_en && (stall_q != '1)) begin
            stall_q <= stall_q + CNT_W'(1);
         end
         if (enter_redir && (redir_q != '1)) begin
            redir_q <= redir_q + CNT_W'(1);
         end
      end
   end

   assign stall_count    = stall_q;
   assign redirect_count = redir_q;
`else
   assign stall_count    = '0;
   assign redirect_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl.
// Output vector order: pc,ifid,idex,exmem enables; ifid,idex,exmem flushes; md_start.
module tb_pipeline_hazard_ctrl;

   localparam int CNT_W = 32;
`ifdef PIPELINE_HAZARD_CTRL_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   localparam logic [7:0] O_RST  = 8'b0000_0000;
   localparam logic [7:0] O_DEF  = 8'b1111_0000;
   localparam logic [7:0] O_RDR  = 8'b1111_1100;
   localparam logic [7:0] O_RDS  = 8'b1111_1000;
   localparam logic [7:0] O_MDS  = 8'b0001_0011;
   localparam logic [7:0] O_MDW  = 8'b0001_0010;
   localparam logic [7:0] O_LU   = 8'b0011_0100;

   logic             clk = 1'b0;
   logic             rst;
   logic [4:0]       id_rs1, id_rs2, ex_rd;
   logic             id_uses_rs1, id_uses_rs2;
   logic             ex_mem_read, ex_redirect, ex_md_valid, md_done;
   logic             if_pc_en, if_id_en, id_ex_en, ex_mem_en;
   logic             if_id_flush, id_ex_flush, ex_mem_flush, md_start;
   logic [1:0]       ctrl_state;
   logic [CNT_W-1:0] stall_count, redirect_count;

   int checks   = 0;
   int failures = 0;
   int exp_stall = 0;
   int exp_redir = 0;

   pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
      .ex_redirect(ex_redirect), .ex_md_valid(ex_md_valid),
      .md_done(md_done),
      .if_pc_en(if_pc_en), .if_id_en(if_id_en),
      .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
      .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
      .ex_mem_flush(ex_mem_flush), .md_start(md_start),
      .ctrl_state(ctrl_state),
      .stall_count(stall_count), .redirect_count(redirect_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input string tag, input logic [7:0] exp_o,
                      input logic [1:0] exp_s, input bit chk_s);
      #1;
      chk({tag, "_out"},
          {24'd0, if_pc_en, if_id_en, id_ex_en, ex_mem_en,
           if_id_flush, id_ex_flush, ex_mem_flush, md_start},
          {24'd0, exp_o});
      if (chk_s) chk({tag, "_st"}, {30'd0, ctrl_state}, {30'd0, exp_s});
      if (!rst && !exp_o[7]) exp_stall++;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_cnt(input string tag);
      chk({tag, "_stall"}, stall_count, PERF ? exp_stall : 0);
      chk({tag, "_redir"}, redirect_count, PERF ? exp_redir : 0);
   endtask

   task automatic idle();
      id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
      id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
      ex_mem_read = 1'b0; ex_redirect = 1'b0;
      ex_md_valid = 1'b0; md_done = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      @(posedge clk);
      #1;
      cyc("reset", O_RST, 2'd0, 1'b1);
      chk_cnt("reset");
      rst = 1'b0;
      cyc("idle", O_DEF, 2'd0, 1'b1);

      // lw x5 in EX, add in ID reads x5 via rs2
      ex_mem_read = 1'b1; ex_rd = 5'd5;
      id_rs1 = 5'd3; id_uses_rs1 = 1'b1;
      id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
      cyc("lu_rs2", O_LU, 2'd0, 1'b1);
      idle();
      cyc("lu_bubble", O_DEF, 2'd0, 1'b1);
      chk_cnt("lu_rs2");

      ex_mem_read = 1'b1; ex_rd = 5'd7;
      id_rs1 = 5'd7; id_uses_rs1 = 1'b1;
      cyc("lu_rs1", O_LU, 2'd0, 1'b1);
      id_uses_rs1 = 1'b0;
      cyc("lu_unused", O_DEF, 2'd0, 1'b1);

      ex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
      cyc("lu_x0", O_DEF, 2'd0, 1'b1);
      idle();

      md_done = 1'b1;
      cyc("done_in_run", O_DEF, 2'd0, 1'b1);
      md_done = 1'b0;
      chk_cnt("pre_md");

      // divide: one start cycle, ten waiting, then done
      ex_md_valid = 1'b1;
      cyc("md_start", O_MDS, 2'd0, 1'b1);
      for (int i = 0; i < 10; i++) cyc("md_wait", O_MDW, 2'd1, 1'b1);
      md_done = 1'b1;
      cyc("md_done", O_DEF, 2'd1, 1'b1);
      idle();
      cyc("md_after", O_DEF, 2'd0, 1'b1);
      chk_cnt("md");

      // redirect beats a simultaneous load-use
      ex_redirect = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd9;
      id_rs1 = 5'd9; id_uses_rs1 = 1'b1;
      exp_redir++;
      cyc("rdr_run", O_RDR, 2'd0, 1'b1);
      ex_md_valid = 1'b1;
      cyc("rdr_state", O_RDS, 2'd2, 1'b1);
      idle();
      cyc("rdr_after", O_DEF, 2'd0, 1'b1);
      chk_cnt("rdr");

      // reset in the middle of a divide
      ex_md_valid = 1'b1;
      cyc("rmd_start", O_MDS, 2'd0, 1'b1);
      for (int i = 0; i < 3; i++) cyc("rmd_wait", O_MDW, 2'd1, 1'b1);
      rst = 1'b1;
      exp_stall = 0;
      exp_redir = 0;
      cyc("rmd_rst0", O_RST, 2'd1, 1'b0);
      cyc("rmd_rst1", O_RST, 2'd0, 1'b1);
      rst = 1'b0;
      idle();
      chk_cnt("rmd");
      cyc("rmd_after", O_DEF, 2'd0, 1'b1);
      chk_cnt("rmd_after");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
